// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access unit and the memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ack_i;
  logic [31:0]       mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: req/ack transaction, pipeline stall, load extraction.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned word accesses instead of aligning down).
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int WAIT_CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic                  MemByte_i,
  input  logic                  MemSigned_i,
  input  logic [ADDR_W-1:0]     Addr_i,
  input  logic [31:0]           WrData_i,
  output logic [31:0]           RDData_o,
  output logic                  Stall_o,
  output logic                  Misalign_o,
  output logic [WAIT_CNT_W-1:0] WaitCycles_o,
  mem_access_unit_if.master     mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_access;
  logic                  w_trap;
  logic                  w_issue;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;
  logic                  r_load;
  logic                  r_byte;
  logic                  r_signed;
  logic [1:0]            r_lane;
  logic [WAIT_CNT_W-1:0] r_wait;
  logic [31:0]           r_rddata;
  logic [7:0]            w_byte;
  logic [31:0]           w_load_data;

  assign w_access = MemRead_i | MemWrite_i;

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_trap     = w_access & ~MemByte_i & (Addr_i[1:0] != 2'b00);
  assign Misalign_o = r_misalign;
`else
  assign w_trap     = 1'b0;
  assign Misalign_o = 1'b0;
`endif

  assign w_issue = (r_state == S_IDLE) & w_access & ~w_trap;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Stall is gated by reset so a pending access does not stall while held in reset.
  always_comb begin
    w_next  = r_state;
    Stall_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        Stall_o = w_access & rst_n_i;
        if (w_access) w_next = w_trap ? S_DONE : S_REQ;
      end
      S_REQ: begin
        Stall_o = 1'b1;
        if (mem.mem_ack_i) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_lane)
      2'd0: w_byte = mem.mem_rdata_i[7:0];
      2'd1: w_byte = mem.mem_rdata_i[15:8];
      2'd2: w_byte = mem.mem_rdata_i[23:16];
      2'd3: w_byte = mem.mem_rdata_i[31:24];
      default: w_byte = 8'h00;
    endcase
    w_load_data = r_byte ? {{24{r_signed & w_byte[7]}}, w_byte} : mem.mem_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_load   <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_lane   <= '0;
      r_wait   <= '0;
      r_rddata <= '0;
    end else begin
      if (w_issue) begin
        r_we     <= MemWrite_i;
        r_addr   <= {Addr_i[ADDR_W-1:2], 2'b00};
        r_be     <= MemByte_i ? (4'b0001 << Addr_i[1:0]) : 4'hF;
        r_wdata  <= MemByte_i ? {4{WrData_i[7:0]}} : WrData_i;
        r_load   <= MemRead_i & ~MemWrite_i;
        r_byte   <= MemByte_i;
        r_signed <= MemSigned_i;
        r_lane   <= Addr_i[1:0];
        r_wait   <= '0;
      end
      if (r_state == S_REQ) begin
        if (r_wait != '1) r_wait <= r_wait + WAIT_CNT_W'(1);
        if (mem.mem_ack_i && r_load) r_rddata <= w_load_data;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_misalign <= 1'b0;
    else          r_misalign <= (r_state == S_IDLE) & w_trap;
  end
`endif

  assign mem.mem_req_o   = (r_state == S_REQ);
  assign mem.mem_we_o    = r_we;
  assign mem.mem_addr_o  = r_addr;
  assign mem.mem_be_o    = r_be;
  assign mem.mem_wdata_o = r_wdata;
  assign RDData_o        = r_rddata;
  assign WaitCycles_o    = r_wait;

endmodule
